// File: rtl/pipo_reg.sv
// pipo_reg: word-wide parallel-in, parallel-out register with one cycle of latency
module pipo_reg #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] parallel_out
);
    logic [WIDTH-1:0] q_q = RESET_VALUE;
    logic [WIDTH-1:0] q_d;
    // next word is simply the input; reset overrides it at the edge
    always_comb q_d = parallel_in;
    // all bits load together on the rising edge, reset taking priority
    always_ff @(posedge clk) begin
        if (rst) q_q <= RESET_VALUE;
        else     q_q <= q_d;
    end
    assign parallel_out = q_q;
endmodule

// File: tb/tb_pipo_reg.sv
// tb_pipo_reg: scoreboard bench for pipo_reg at widths 4, 16 and 1
module tb_pipo_reg;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in4 = 4'hF;
    logic [15:0] in16 = 16'hFFFF;
    logic        in1 = 1'b1;
    logic [3:0]  out4;
    logic [15:0] out16;
    logic        out1;
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  q4[$];
    logic [15:0] q16[$];
    logic        q1[$];

    always #5 clk = ~clk;

    pipo_reg u4 (.clk(clk), .rst(rst), .parallel_in(in4), .parallel_out(out4));
    pipo_reg #(.WIDTH(16), .RESET_VALUE(16'hA5A5)) u16 (.clk(clk), .rst(rst), .parallel_in(in16), .parallel_out(out16));
    pipo_reg #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .parallel_in(in1), .parallel_out(out1));

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // apply one word per DUT for the next rising edge and record what it must produce
    task automatic drive(input logic r, input logic [3:0] a4, input logic [15:0] a16, input logic a1);
        rst  = r;
        in4  = a4;
        in16 = a16;
        in1  = a1;
        q4.push_back(r ? 4'h0 : a4);
        q16.push_back(r ? 16'hA5A5 : a16);
        q1.push_back(r ? 1'b0 : a1);
        @(negedge clk);
    endtask

    // monitor: just before the following falling edge, compare each output with the oldest expectation
    initial begin
        forever begin
            @(posedge clk);
            #4;
            if (q4.size() > 0) check("out4", {12'h0, out4}, {12'h0, q4.pop_front()});
            if (q16.size() > 0) check("out16", out16, q16.pop_front());
            if (q1.size() > 0) check("out1", {15'h0, out1}, {15'h0, q1.pop_front()});
        end
    end

    initial begin
        #1;
        check("init4", {12'h0, out4}, 16'h0000);
        check("init16", out16, 16'hA5A5);
        check("init1", {15'h0, out1}, 16'h0000);
        #1;
        q4.push_back(4'h0);
        q16.push_back(16'hA5A5);
        q1.push_back(1'b0);
        @(negedge clk);
        drive(1'b1, 4'b1111, 16'hFFFF, 1'b1);
        drive(1'b0, 4'b1101, 16'hFFFF, 1'b0);
        drive(1'b0, 4'b0110, 16'h0001, 1'b1);
        drive(1'b0, 4'b1001, 16'h1234, 1'b0);
        drive(1'b0, 4'b1010, 16'hBEEF, 1'b1);
        in4 = 4'b0101; in16 = 16'h0F0F; in1 = 1'b0; rst = 1'b1;
        #1 check("glitch4_a", {12'h0, out4}, 16'h000A);
        check("glitch16_a", out16, 16'hBEEF);
        in4 = 4'b1111; rst = 1'b0;
        #1 check("glitch4_b", {12'h0, out4}, 16'h000A);
        in4 = 4'b0000; in1 = 1'b1;
        #1 check("glitch4_c", {12'h0, out4}, 16'h000A);
        check("glitch1_c", {15'h0, out1}, 16'h0001);
        drive(1'b0, 4'b0110, 16'h8001, 1'b0);
        drive(1'b0, 4'b0011, 16'h00FF, 1'b1);
        drive(1'b0, 4'b1100, 16'hFF00, 1'b0);
        drive(1'b1, 4'b1110, 16'h7777, 1'b1);
        drive(1'b0, 4'b0111, 16'h0001, 1'b1);
        drive(1'b0, 4'b0111, 16'h0001, 1'b0);
        for (int i = 0; i < 1000; i++)
            drive($urandom_range(0, 19) == 0, 4'($urandom), 16'($urandom), 1'($urandom));
        @(posedge clk);
        #6;
        check("drained", 16'(q4.size() + q16.size() + q1.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
